// File: rtl/rr_stream_mux.sv
// N-to-1 valid/ready stream mux with round-robin grant, per-packet locking
// and a registered output stage.
module rr_stream_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CH_W     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [CH_W-1:0]           out_chan
);

  // state  | meaning
  // IDLE   | no packet open; grant goes round-robin starting at ptr
  // LOCKED | packet open on lck; only lck may be granted until its last beat

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam int IW = CH_W + 1;

  state_t          state, state_nxt;
  logic [CH_W-1:0] ptr, lck, rr_grant, grant, ptr_nxt;
  logic [IW-1:0]   idx;
  logic            rr_found, load_en, accept;
  logic [WIDTH-1:0] grant_data;

  // Candidate index is computed one bit wider so non-power-of-two counts wrap cleanly.
  always_comb begin
    rr_grant = ptr;
    rr_found = 1'b0;
    idx      = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = {1'b0, ptr} + IW'(k);
      if (idx >= IW'(CHANNELS)) idx = idx - IW'(CHANNELS);
      if (!rr_found && in_valid[idx[CH_W-1:0]]) begin
        rr_grant = idx[CH_W-1:0];
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == CH_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign grant   = (state == LOCKED) ? lck : rr_grant;
  assign load_en = !out_valid || out_ready;
  assign accept  = !rst && load_en && in_valid[grant];
  assign ptr_nxt = (grant == CH_W'(CHANNELS-1)) ? '0 : grant + CH_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = in_last[grant] ? IDLE : LOCKED;
  end

  always_comb begin
    in_ready = '0;
    if (!rst && load_en && (state == LOCKED || rr_found)) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      lck       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else begin
      if (accept) begin
        if (in_last[grant]) ptr <= ptr_nxt;
        else                lck <= grant;
      end
      // An idle load slot drops valid but keeps the last beat visible.
      if (load_en) begin
        out_valid <= accept;
        if (accept) begin
          out_data <= grant_data;
          out_last <= in_last[grant];
          out_chan <= grant;
        end
      end
    end
  end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-to-1 streaming multiplexer with valid/ready handshakes, round-robin arbitration and a registered output stage.
- Successor to the fixed 2x1 combinational mux: generalises to WIDTH-bit data and CHANNELS inputs.
- Adds packet locking: a granted channel keeps the output until its last beat.
- Sits between multiple producer units and a single shared consumer (bus or write port).

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels; must be >= 2.
- CH_W, $clog2(CHANNELS), width of the channel index (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  CHANNELS  per-channel beat valid.
- in_ready  output  CHANNELS  per-channel beat accepted (combinational).
- in_data  input  CHANNELS*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  CHANNELS  per-channel end-of-packet flag.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_data  output  WIDTH  registered output data.
- out_last  output  1  registered end-of-packet flag.
- out_chan  output  CH_W  source channel of the current output beat.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_last=0, out_chan=0, state=IDLE, rr pointer ptr=0, lock channel lck=0. All in_ready=0 while rst=1.
- load_en = !out_valid || out_ready. The output register loads only when load_en=1.
- Beat transfer: an input beat transfers on channel i when in_valid[i] && in_ready[i]. An output beat transfers when out_valid && out_ready.
- States:
  - IDLE: grant g = first i with in_valid[i]=1, searching ptr, ptr+1, ..., wrapping mod CHANNELS.
  - LOCKED: g = lck, regardless of other valids.
- in_ready[i] = load_en && (i == g) && (state==LOCKED || in_valid[i]). At most one bit is set. in_ready does not depend on in_data or in_last.
- On an accepted beat from g:
  - out_valid<=1, out_data<=in_data[g], out_last<=in_last[g], out_chan<=g.
  - If in_last[g]=0: state<=LOCKED, lck<=g.
  - If in_last[g]=1: state<=IDLE, ptr<=(g+1) mod CHANNELS. This also applies to single-beat packets accepted from IDLE.
- If load_en=1 and no beat is accepted: out_valid<=0, and out_data/out_last/out_chan hold their values.
- If load_en=0: the output register holds and state is unchanged. in_valid may toggle freely with no effect.
- Latency and throughput: 1 cycle from input acceptance to out_valid. Full rate (1 beat/cycle) is sustained while out_ready=1.
- Simultaneous events: an output drain and a new load in the same cycle replace the beat with no bubble.
- LOCKED with in_valid[lck]=0: the output drains and no other channel is granted (no interleaving within a packet).
- Wrap-around: ptr=CHANNELS-1 with a last beat accepted sets ptr=0. CHANNELS that are not a power of two must wrap correctly (e.g. 3 -> 0).
- Reset mid-packet: the lock is dropped, and the output beat and any partially transferred packet are discarded. The source is responsible for recovery.
- No combinational path from out_ready to out_*. A combinational path from out_ready to in_ready is permitted.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_chan=0, in_ready=0 immediately (asynchronous); after release, the first grant goes to ch0 when all valid.
- Round-robin: CHANNELS=4, all channels send single-beat packets (last=1) continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1; out_data matches each channel's value (e.g. 8'hA0+i).
- Packet lock: ch2 sends 3 beats (last on the third) while ch0 and ch1 are valid -> out_chan=2,2,2, then 0. in_ready[0]=in_ready[1]=0 throughout the packet, even during a ch2 valid gap of 2 cycles.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 -> out_data stable, in_ready all 0. Release -> one beat per cycle, no beat lost or duplicated (scoreboard count equal).
- Wrap and non-power-of-two: CHANNELS=3, ptr=2, ch2 and ch0 valid -> ch2 first, then ch0. After ch2's last beat, ptr=0.
- Idle bubble: in_valid=0 with out_ready=1 -> out_valid drops after one cycle; out_data retains its last value.
